// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Instruction fetch unit with a small in-order instruction queue. It issues
//   one word-address read at a time to instruction memory, pushes each returned
//   word with its PC+1 into a DEPTH-entry queue, and presents the head entry to
//   decode. A branch redirect flushes the queue and restarts fetching at the
//   target. Enqueueing a HLT (opcode 6'b111111) stops fetching until the next
//   redirect.
//
// Ports
//   clk1         in   single clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   imem_req     out  read request, held until imem_gnt
//   imem_addr    out  request word address (fetch_pc[AW-1:0])
//   imem_gnt     in   memory accepts the request this cycle
//   imem_rvalid  in   read data valid
//   imem_rdata   in   instruction word
//   redirect     in   taken branch: flush and restart at redirect_pc
//   redirect_pc  in   branch target
//   dec_ready    in   decode accepts the head entry
//   if_valid     out  queue non-empty
//   if_ir        out  head instruction (0 when empty)
//   if_npc       out  head instruction PC+1 (0 when empty)
//   fetch_pc     out  next PC to request
//   fill         out  queue occupancy
//   halted       out  a HLT has been enqueued and fetching has stopped
module instr_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 10
) (
  input  logic                     clk1,
  input  logic                     rst_n,
  output logic                     imem_req,
  output logic [AW-1:0]            imem_addr,
  input  logic                     imem_gnt,
  input  logic                     imem_rvalid,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     dec_ready,
  output logic                     if_valid,
  output logic [31:0]              if_ir,
  output logic [31:0]              if_npc,
  output logic [31:0]              fetch_pc,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     halted
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_W = (PW+1)'(DEPTH);

  typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} state_t;

  state_t          r_state;
  logic [31:0]     r_fetchPc;
  logic [PW:0]     r_fill;
  logic [PW-1:0]   r_rdPtr;
  logic [PW-1:0]   r_wrPtr;
  logic            r_halted;
  logic [31:0]     r_irMem  [DEPTH];
  logic [31:0]     r_npcMem [DEPTH];

  logic            w_push;
  logic            w_pop;
  logic            w_isHlt;
  logic [PW:0]     w_fillNext;
  logic [31:0]     w_npcNew;

  // A response is only accepted while waiting for it, and a redirect in the
  // same cycle kills both the response and any pop.
  assign w_push     = (r_state == WAIT) && imem_rvalid && !redirect;
  assign w_pop      = (r_fill != '0) && dec_ready && !redirect;
  assign w_isHlt    = (imem_rdata[31:26] == 6'b111111);
  assign w_fillNext = r_fill + {{PW{1'b0}}, w_push} - {{PW{1'b0}}, w_pop};
  assign w_npcNew   = r_fetchPc + 32'd1;

  // Fetch FSM, queue pointers and occupancy. The only outstanding request is
  // the one implied by being in WAIT or DRAIN, so the credit check in IDLE
  // only needs the occupancy. A redirect while a response is still owed goes
  // through DRAIN so that stale word is swallowed instead of pushed.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_fetchPc <= '0;
      r_fill    <= '0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_halted  <= 1'b0;
    end else if (redirect) begin
      r_fill    <= '0;
      r_rdPtr   <= '0;
      r_wrPtr   <= '0;
      r_fetchPc <= redirect_pc;
      r_halted  <= 1'b0;
      if ((r_state == WAIT  && !imem_rvalid) ||
          (r_state == DRAIN && !imem_rvalid) ||
          (r_state == REQ   && imem_gnt))
        r_state <= DRAIN;
      else
        r_state <= REQ;
    end else begin
      r_fill <= w_fillNext;
      if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
      case (r_state)
        IDLE: begin
          if ((r_fill < DEPTH_W) && !r_halted) r_state <= REQ;
        end
        REQ: begin
          if (imem_gnt) r_state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            r_fetchPc <= w_npcNew;
            if (w_isHlt) begin
              r_state  <= HALT;
              r_halted <= 1'b1;
            end else if (w_fillNext < DEPTH_W) begin
              r_state <= REQ;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        DRAIN: begin
          if (imem_rvalid) r_state <= REQ;
        end
        HALT: begin
          r_state <= HALT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Queue payload storage; contents are only meaningful below the fill count,
  // so it needs no reset.
  always_ff @(posedge clk1) begin
    if (w_push) begin
      r_irMem[r_wrPtr]  <= imem_rdata;
      r_npcMem[r_wrPtr] <= w_npcNew;
    end
  end

  assign imem_req  = (r_state == REQ);
  assign imem_addr = r_fetchPc[AW-1:0];
  assign if_valid  = (r_fill != '0);
  assign if_ir     = if_valid ? r_irMem[r_rdPtr]  : 32'd0;
  assign if_npc    = if_valid ? r_npcMem[r_rdPtr] : 32'd0;
  assign fetch_pc  = r_fetchPc;
  assign fill      = r_fill;
  assign halted    = r_halted;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue
//   Directed and randomized checks of instr_fetch_queue against a program
//   memory model and an in-order instruction stream model.
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 10;

  localparam logic [31:0] OP_ADD  = 32'h0062_0820;
  localparam logic [31:0] OP_SUB  = 32'h0062_0822;
  localparam logic [31:0] OP_ADDI = 32'h2021_0005;
  localparam logic [31:0] OP_HLT  = 32'hFC00_0000;

  logic                   clk1;
  logic                   rst_n;
  logic                   imem_req;
  logic [AW-1:0]          imem_addr;
  logic                   imem_gnt;
  logic                   imem_rvalid;
  logic [31:0]            imem_rdata;
  logic                   redirect;
  logic [31:0]            redirect_pc;
  logic                   dec_ready;
  logic                   if_valid;
  logic [31:0]            if_ir;
  logic [31:0]            if_npc;
  logic [31:0]            fetch_pc;
  logic [$clog2(DEPTH):0] fill;
  logic                   halted;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem [1024];

  // memory model controls
  int          memLatency = 1;
  int          gntPct     = 100;
  bit          memManual  = 1'b0;
  logic        autoGnt    = 1'b0;
  logic        autoRvalid = 1'b0;
  logic [31:0] autoRdata  = 32'd0;
  logic        manGnt     = 1'b0;
  logic        manRvalid  = 1'b0;
  logic [31:0] manRdata   = 32'd0;
  bit          respActive = 1'b0;
  int          respCnt    = 0;
  logic [AW-1:0] respAddr = '0;

  // instruction stream model: next expected PC at the decode interface
  logic [31:0] modelPc;
  int          pops;
  bit          overflowSeen;
  bit          found;

  instr_fetch_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .dec_ready   (dec_ready),
    .if_valid    (if_valid),
    .if_ir       (if_ir),
    .if_npc      (if_npc),
    .fetch_pc    (fetch_pc),
    .fill        (fill),
    .halted      (halted)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  assign imem_gnt    = memManual ? manGnt    : autoGnt;
  assign imem_rvalid = memManual ? manRvalid : autoRvalid;
  assign imem_rdata  = memManual ? manRdata  : autoRdata;

  // Memory responder: decides grants on the falling edge so they are stable
  // for the next rising edge, and returns the granted word memLatency cycles
  // after the grant edge.
  always @(negedge clk1) begin
    autoRvalid = 1'b0;
    if (memManual) begin
      respActive = 1'b0;
      autoGnt    = 1'b0;
    end else begin
      if (respActive) begin
        respCnt = respCnt - 1;
        if (respCnt == 0) begin
          autoRvalid = 1'b1;
          autoRdata  = mem[respAddr];
          respActive = 1'b0;
        end
      end
      autoGnt = imem_req && (int'($urandom_range(0, 99)) < gntPct);
      if (autoGnt) begin
        respActive = 1'b1;
        respAddr   = imem_addr;
        respCnt    = memLatency;
      end
    end
  end

  function automatic logic [31:0] normalWord(input int a);
    return {6'b000001, 16'(a * 7 + 3), 10'(a)};
  endfunction

  task automatic tick();
    @(posedge clk1);
    #1;
  endtask

  task automatic applyStimulus(input logic decReady, input logic redir, input logic [31:0] redirPc);
    dec_ready   = decReady;
    redirect    = redir;
    redirect_pc = redirPc;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // If decode takes the head this cycle, it must be the next word of the
  // program stream together with its PC+1.
  task automatic observePop();
    if (if_valid && dec_ready) begin
      checkOutput("pop", {if_ir, if_npc}, {mem[modelPc[AW-1:0]], modelPc + 32'd1});
      modelPc = modelPc + 32'd1;
      pops++;
    end
  endtask

  task automatic manualFetch(input logic [31:0] word);
    manGnt = 1'b1;
    tick();
    manGnt    = 1'b0;
    manRvalid = 1'b1;
    manRdata  = word;
    tick();
    manRvalid = 1'b0;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = normalWord(a);
    mem[0] = OP_ADD;
    mem[1] = OP_SUB;
    mem[2] = OP_ADDI;
    mem[3] = OP_HLT;

    // ---- reset values and first request timing
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rstFill",    64'(fill),     64'd0);
    checkOutput("rstValid",   64'(if_valid), 64'd0);
    checkOutput("rstIr",      64'(if_ir),    64'd0);
    checkOutput("rstNpc",     64'(if_npc),   64'd0);
    checkOutput("rstReq",     64'(imem_req), 64'd0);
    checkOutput("rstHalted",  64'(halted),   64'd0);
    checkOutput("rstFetchPc", 64'(fetch_pc), 64'd0);
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checkOutput("reqBeforeEdge1", 64'(imem_req), 64'd0);
    tick();
    checkOutput("reqAfterEdge1", 64'(imem_req), 64'd1);
    checkOutput("firstAddr", 64'(imem_addr), 64'd0);

    // ---- ADD, SUB, ADDI, HLT program with decode always ready
    modelPc = 32'd0;
    pops    = 0;
    for (int i = 0; i < 30; i++) begin
      observePop();
      tick();
    end
    checkOutput("haltPops",    64'(pops),     64'd4);
    checkOutput("haltFlag",    64'(halted),   64'd1);
    checkOutput("haltReq",     64'(imem_req), 64'd0);
    checkOutput("haltFetchPc", 64'(fetch_pc), 64'd4);
    checkOutput("haltFill",    64'(fill),     64'd0);

    // ---- fill to DEPTH with decode stalled, then release one slot
    mem[3] = normalWord(3);
    applyStimulus(1'b0, 1'b1, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("redirHalted", 64'(halted),   64'd0);
    checkOutput("redirFill",   64'(fill),     64'd0);
    checkOutput("redirReq",    64'(imem_req), 64'd1);
    repeat (20) tick();
    checkOutput("fullFill",    64'(fill),     64'd4);
    checkOutput("fullReq",     64'(imem_req), 64'd0);
    checkOutput("fullFetchPc", 64'(fetch_pc), 64'd4);
    checkOutput("fullHead",    {if_ir, if_npc}, {mem[0], 32'd1});
    applyStimulus(1'b1, 1'b0, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("popFill", 64'(fill), 64'd3);
    checkOutput("popHead", {if_ir, if_npc}, {mem[1], 32'd2});
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (imem_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("refillReqSeen", 64'(found), 64'd1);
    checkOutput("refillAddr", 64'(imem_addr), 64'd4);
    repeat (6) tick();
    checkOutput("refillFill",    64'(fill),     64'd4);
    checkOutput("refillFetchPc", 64'(fetch_pc), 64'd5);
    checkOutput("refillReqOff",  64'(imem_req), 64'd0);

    // ---- redirect while waiting for the word at address 2
    memLatency = 3;
    applyStimulus(1'b0, 1'b1, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req && imem_addr == 10'd2) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("addr2ReqSeen", 64'(found), 64'd1);
    tick();
    applyStimulus(1'b0, 1'b1, 32'h20);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("drainFill",    64'(fill),     64'd0);
    checkOutput("drainValid",   64'(if_valid), 64'd0);
    checkOutput("drainFetchPc", 64'(fetch_pc), 64'h20);
    checkOutput("drainReq",     64'(imem_req), 64'd0);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (imem_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("targetReqSeen", 64'(found), 64'd1);
    checkOutput("targetAddr", 64'(imem_addr), 64'h20);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (if_valid) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("targetValidSeen", 64'(found), 64'd1);
    checkOutput("targetHead", {if_ir, if_npc}, {mem[32'h20], 32'h21});
    checkOutput("targetFill", 64'(fill), 64'd1);

    // ---- redirect coinciding with rvalid and a pop, fill=2
    memManual = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checkOutput("manReq", {32'(imem_req), 32'(imem_addr)}, {32'd1, 32'd0});
    manualFetch(mem[0]);
    checkOutput("latencyValid", 64'(if_valid), 64'd1);
    checkOutput("latencyHead", {if_ir, if_npc}, {mem[0], 32'd1});
    manualFetch(mem[1]);
    checkOutput("twoFill",    64'(fill),     64'd2);
    checkOutput("twoFetchPc", 64'(fetch_pc), 64'd2);
    manGnt = 1'b1;
    tick();
    manGnt    = 1'b0;
    manRvalid = 1'b1;
    manRdata  = mem[2];
    applyStimulus(1'b1, 1'b1, 32'h40);
    tick();
    manRvalid = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'd0);
    checkOutput("coFill",    64'(fill),     64'd0);
    checkOutput("coValid",   64'(if_valid), 64'd0);
    checkOutput("coFetchPc", 64'(fetch_pc), 64'h40);
    checkOutput("coReq", {32'(imem_req), 32'(imem_addr)}, {32'd1, 32'h40});
    manRvalid = 1'b1;
    manRdata  = mem[5];
    tick();
    manRvalid = 1'b0;
    checkOutput("strayRvalidFill", 64'(fill), 64'd0);

    // ---- PC wrap at 2^32
    memManual  = 1'b0;
    memLatency = 1;
    gntPct     = 100;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFF);
    tick();
    applyStimulus(1'b0, 1'b0, 32'd0);
    repeat (25) tick();
    checkOutput("wrapFill",    64'(fill),      64'd4);
    checkOutput("wrapFetchPc", 64'(fetch_pc),  64'd3);
    checkOutput("wrapAddr",    64'(imem_addr), 64'd3);
    checkOutput("wrapHead", {if_ir, if_npc}, {mem[1023], 32'd0});

    // ---- random gnt stalls, latency 3, random decode back-pressure
    memLatency = 3;
    gntPct     = 50;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    modelPc      = 32'd0;
    pops         = 0;
    overflowSeen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      dec_ready = ($urandom_range(0, 2) != 0);
      observePop();
      if (fill > 3'(DEPTH)) overflowSeen = 1'b1;
      if (pops == 100) break;
      tick();
    end
    dec_ready = 1'b0;
    checkOutput("streamPops", 64'(pops), 64'd100);
    checkOutput("streamOverflow", 64'(overflowSeen), 64'd0);

    // ---- asynchronous reset in WAIT with fill=3, then a late response
    gntPct = 100;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (fill == 3'd3 && imem_req) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    checkOutput("fill3ReqSeen", 64'(found), 64'd1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    gntPct = 0;
    checkOutput("asyncFill",    64'(fill),     64'd0);
    checkOutput("asyncValid",   64'(if_valid), 64'd0);
    checkOutput("asyncIr",      64'(if_ir),    64'd0);
    checkOutput("asyncReq",     64'(imem_req), 64'd0);
    checkOutput("asyncFetchPc", 64'(fetch_pc), 64'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("lateFill",  64'(fill),     64'd0);
    checkOutput("lateValid", 64'(if_valid), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4: number of instruction queue entries; a power of two, 2..16.
REQ-002 Parameter AW, default 10: instruction memory word-address width, covering 1024 words.
REQ-003 clk1  in  1  single clock; all state changes on the rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 imem_req  out  1  instruction memory read request; held until granted.
REQ-006 imem_addr  out  AW  word address of the request; equals fetch_pc[AW-1:0].
REQ-007 imem_gnt  in  1  memory accepts the request this cycle.
REQ-008 imem_rvalid  in  1  read data valid; arrives at least 1 cycle after the grant.
REQ-009 imem_rdata  in  32  instruction word.
REQ-010 redirect  in  1  branch taken in execute: flush and restart.
REQ-011 redirect_pc  in  32  branch target (NPC+IMM).
REQ-012 dec_ready  in  1  decode stage accepts the head entry.
REQ-013 if_valid  out  1  queue non-empty.
REQ-014 if_ir  out  32  head instruction; 0 when the queue is empty.
REQ-015 if_npc  out  32  head instruction PC+1.
REQ-016 fetch_pc  out  32  next PC to request.
REQ-017 fill  out  $clog2(DEPTH)+1  queue occupancy.
REQ-018 halted  out  1  a HLT (opcode 6'b111111) has been enqueued; fetching has stopped.

Function
REQ-019 FSM states: IDLE, REQ, WAIT, DRAIN, HALT.
REQ-020 IDLE -> REQ when fill + outstanding < DEPTH and not halted.
REQ-021 In REQ, imem_req=1. REQ -> WAIT on imem_gnt. At most 1 outstanding request at any time.
REQ-022 In WAIT, on imem_rvalid:
- push {imem_rdata, fetch_pc+1} into the queue;
- fetch_pc <= fetch_pc+1;
- if imem_rdata[31:26]==6'b111111, go to HALT; otherwise go to REQ if credit remains, else IDLE.
REQ-023 Response-to-if_valid latency: 1 cycle when the queue is empty, i.e. the entry is visible the cycle after rvalid.
REQ-024 Pop when if_valid && dec_ready. A push and a pop in the same cycle leave fill unchanged.
REQ-025 Credit rule: a push never occurs when full. Because a request is issued only with a free slot, overflow is impossible.
REQ-026 Pop with the queue empty is ignored. fill never underflows.
REQ-027 Queue pointers wrap modulo DEPTH.
REQ-028 redirect in any state:
- queue cleared (fill=0, if_valid=0 next cycle);
- fetch_pc <= redirect_pc;
- halted cleared;
- a pop in the same cycle is discarded.
REQ-029 redirect while in WAIT, or in REQ with imem_gnt=1 the same cycle: go to DRAIN. The pending response is discarded, then go to REQ.
REQ-030 redirect in any other state: go to REQ next cycle.
REQ-031 redirect coincident with imem_rvalid: the response is discarded and not pushed.
REQ-032 HALT state: no requests; the queue keeps draining to decode. Exit only via redirect or reset.
REQ-033 if_npc and fetch_pc arithmetic is 32-bit and wraps at 2^32-1 -> 0. imem_addr is the truncated low AW bits.
REQ-034 imem_rvalid outside WAIT/DRAIN is ignored.

Reset
REQ-035 On rst_n low, immediately and independent of clk1:
- state=IDLE; fetch_pc=0; fill=0;
- if_valid=0; if_ir=0; if_npc=0;
- imem_req=0; halted=0;
- outstanding cleared.
REQ-036 Reset mid-WAIT: a response arriving after release is ignored, because the FSM is in IDLE.
REQ-037 First request is issued the 2nd clk1 edge after rst_n rises: IDLE->REQ, then imem_req=1.

Verification
REQ-038 Memory with 1-cycle latency; words 0..3 = ADD, SUB, ADDI, HLT; dec_ready=1 -> if_ir/if_npc sequence (ADD,1), (SUB,2), (ADDI,3), (HLT,4); halted=1; imem_req stays 0 afterwards.
REQ-039 dec_ready=0, DEPTH=4 -> fill reaches 4; imem_req=0; fetch_pc=4. Raising dec_ready for 1 cycle -> fill=3, then one new request to address 4.
REQ-040 Redirect to 0x20 while in WAIT for address 2 -> the stale response is dropped; fill=0; the next imem_addr is 0x20 and its entry has if_npc=0x21.
REQ-041 Redirect in the same cycle as imem_rvalid and dec_ready with fill=2 -> fill=0, no push, no pop; fetch_pc=redirect_pc.
REQ-042 Memory latency of 3 cycles with random gnt stalls -> in-order delivery, no duplicate or lost entries across 100 sequential words.
REQ-043 Assert rst_n=0 in WAIT with fill=3 -> outputs go to reset values within the same cycle. A late rvalid after release -> fill stays 0.
